// File: rtl/basic_computer_pkg.sv
// Shared definitions for the basic computer datapath: data width and the
// register-reference op encoding used by the AC/E register stage.
package basic_computer_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDAE = 4'd1,
    OP_LDA  = 4'd2,
    OP_CLA  = 4'd3,
    OP_CLE  = 4'd4,
    OP_CMA  = 4'd5,
    OP_CME  = 4'd6,
    OP_CIR  = 4'd7,
    OP_CIL  = 4'd8,
    OP_INC  = 4'd9
  } op_e;

  // Codes above this value are illegal and only raise op_err.
  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/ac_e_register_if.sv
// Bundle of the AC/E register stage signals: op request and ALU inputs from
// the master side, register contents, flags and status pulses back.
interface ac_e_register_if #(
  parameter int WIDTH = 16
);
  // op_valid/op form a valid-only request: no ready exists because the stage
  // accepts one op on every rising edge where op_valid is high.
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_e;
  logic [WIDTH-1:0] ac;
  logic             e;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_e_zero;
  logic             op_done;
  logic             op_err;

  modport master (
    output op_valid, op, alu_result, alu_e,
    input  ac, e, flag_zero, flag_neg, flag_e_zero, op_done, op_err
  );

  modport slave (
    input  op_valid, op, alu_result, alu_e,
    output ac, e, flag_zero, flag_neg, flag_e_zero, op_done, op_err
  );

endinterface

// File: rtl/ac_e_register.sv
// Accumulator and E flip-flop stage: loads ALU results, runs the
// register-reference ops on AC/E and drives the skip-condition flags.
module ac_e_register #(
  parameter int WIDTH = basic_computer_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_e,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_e_zero,
  output logic             op_done,
  output logic             op_err
);
  import basic_computer_pkg::*;

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic             op_done_q, op_done_d;
  logic             op_err_q, op_err_d;

  always_comb begin
    ac_d      = ac_q;
    e_d       = e_q;
    op_done_d = 1'b0;
    op_err_d  = 1'b0;
    if (op_valid) begin
      if (!op_is_legal(op)) begin
        op_err_d = 1'b1;
      end else begin
        op_done_d = 1'b1;
        case (op_e'(op))
          OP_LDAE: {e_d, ac_d} = {alu_e, alu_result};
          OP_LDA:  ac_d = alu_result;
          OP_CLA:  ac_d = '0;
          OP_CLE:  e_d = 1'b0;
          OP_CMA:  ac_d = ~ac_q;
          OP_CME:  e_d = ~e_q;
          // Rotates run through E as one WIDTH+1 bit ring.
          OP_CIR:  {ac_d, e_d} = {e_q, ac_q};
          OP_CIL:  {e_d, ac_d} = {ac_q, e_q};
          OP_INC:  ac_d = ac_q + WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q      <= '0;
      e_q       <= 1'b0;
      op_done_q <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      ac_q      <= ac_d;
      e_q       <= e_d;
      op_done_q <= op_done_d;
      op_err_q  <= op_err_d;
    end
  end

  assign ac          = ac_q;
  assign e           = e_q;
  assign op_done     = op_done_q;
  assign op_err      = op_err_q;
  assign flag_zero   = (ac_q == '0);
  assign flag_neg    = ac_q[WIDTH-1];
  assign flag_e_zero = ~e_q;

endmodule

// File: tb/tb_ac_e_register.sv
// Self-checking bench for ac_e_register: directed scenarios followed by
// random op streams compared against an arithmetic reference model.
module tb_ac_e_register;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ac_e_register_if #(.WIDTH(W)) bus ();

  ac_e_register #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (bus.op_valid),
    .op          (bus.op),
    .alu_result  (bus.alu_result),
    .alu_e       (bus.alu_e),
    .ac          (bus.ac),
    .e           (bus.e),
    .flag_zero   (bus.flag_zero),
    .flag_neg    (bus.flag_neg),
    .flag_e_zero (bus.flag_e_zero),
    .op_done     (bus.op_done),
    .op_err      (bus.op_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: AC value, E bit, and the status expected for the last op.
  logic [W-1:0] m_ac;
  logic         m_e;
  logic         m_done;
  logic         m_err;
  logic [W+2:0] exp_q[$];   // {done, err, e, ac}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ac   = '0;
    m_e    = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  // The rotates treat {ac,e} as one integer ring of W+1 bits.
  task automatic model_step(input logic v, input logic [3:0] o,
                            input logic [W-1:0] res, input logic ae);
    int ring;
    int ring_mask;
    ring_mask = (1 << (W + 1)) - 1;
    ring      = int'(m_ac) * 2 + int'(m_e);
    m_done    = 1'b0;
    m_err     = 1'b0;
    if (v) begin
      if (int'(o) > 9) begin
        m_err = 1'b1;
      end else begin
        m_done = 1'b1;
        case (int'(o))
          1: begin m_ac = res; m_e = ae; end
          2: m_ac = res;
          3: m_ac = '0;
          4: m_e = 1'b0;
          5: m_ac = W'((1 << W) - 1 - int'(m_ac));
          6: m_e = (m_e == 1'b0);
          7: begin
            ring = (ring >> 1) | ((ring & 1) << W);
            m_ac = W'(ring >> 1);
            m_e  = ring[0];
          end
          8: begin
            ring = ((ring << 1) & ring_mask) | (ring >> W);
            m_ac = W'(ring >> 1);
            m_e  = ring[0];
          end
          9: m_ac = W'((int'(m_ac) + 1) % (1 << W));
          default: ;
        endcase
      end
    end
    exp_q.push_back({m_done, m_err, m_e, m_ac});
  endtask

  task automatic check_outputs(input string tag);
    logic [W+2:0] x;
    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    check({tag, ".ac"},          32'(bus.ac),          32'(x[W-1:0]));
    check({tag, ".e"},           32'(bus.e),           32'(x[W]));
    check({tag, ".flag_zero"},   32'(bus.flag_zero),   32'(x[W-1:0] == '0));
    check({tag, ".flag_neg"},    32'(bus.flag_neg),    32'(x[W-1]));
    check({tag, ".flag_e_zero"}, 32'(bus.flag_e_zero), 32'(x[W] == 1'b0));
    check({tag, ".op_err"},      32'(bus.op_err),      32'(x[W+1]));
    check({tag, ".op_done"},     32'(bus.op_done),     32'(x[W+2]));
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic drive_op(input string tag, input logic v, input logic [3:0] o,
                          input logic [W-1:0] res, input logic ae);
    bus.op_valid   = v;
    bus.op         = o;
    bus.alu_result = res;
    bus.alu_e      = ae;
    @(posedge clk);
    model_step(v, o, res, ae);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ac"},          32'(bus.ac),          32'h0);
    check({tag, ".e"},           32'(bus.e),           32'h0);
    check({tag, ".flag_zero"},   32'(bus.flag_zero),   32'h1);
    check({tag, ".flag_neg"},    32'(bus.flag_neg),    32'h0);
    check({tag, ".flag_e_zero"}, 32'(bus.flag_e_zero), 32'h1);
    check({tag, ".op_done"},     32'(bus.op_done),     32'h0);
    check({tag, ".op_err"},      32'(bus.op_err),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.op_valid   = 1'b0;
    bus.op         = 4'd0;
    bus.alu_result = '0;
    bus.alu_e      = 1'b0;
    model_reset();
    #3;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset with a loaded AC and a pending op.
    drive_op("ld1234", 1'b1, 4'd1, 16'h1234, 1'b1);
    #2;
    rst_n          = 1'b0;
    bus.op_valid   = 1'b1;
    bus.op         = 4'd2;
    bus.alu_result = 16'hBEEF;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_values("rst_discard");
    bus.op_valid = 1'b0;
    rst_n        = 1'b1;
    model_reset();

    drive_op("ldae_ffff", 1'b1, 4'd1, 16'hFFFF, 1'b1);
    drive_op("lda_00a5",  1'b1, 4'd2, 16'h00A5, 1'b0);

    drive_op("ld_8001", 1'b1, 4'd1, 16'h8001, 1'b0);
    drive_op("cir",     1'b1, 4'd7, 16'h0000, 1'b0);
    check("cir_ac_direct", 32'(bus.ac), 32'h4000);
    check("cir_e_direct",  32'(bus.e),  32'h1);
    drive_op("cil",     1'b1, 4'd8, 16'h0000, 1'b0);
    for (int i = 0; i < 17; i++) drive_op("cil17", 1'b1, 4'd8, 16'($urandom), 1'($urandom));
    check("cil17_ac_direct", 32'(bus.ac), 32'h8001);
    check("cil17_e_direct",  32'(bus.e),  32'h0);

    drive_op("ld_ffff", 1'b1, 4'd1, 16'hFFFF, 1'b0);
    drive_op("inc_wrap", 1'b1, 4'd9, 16'h1234, 1'b1);
    check("inc_wrap_ac_direct", 32'(bus.ac), 32'h0);
    drive_op("cma", 1'b1, 4'd5, 16'h0, 1'b0);
    drive_op("cme", 1'b1, 4'd6, 16'h0, 1'b0);

    drive_op("nop",     1'b1, 4'd0,  16'h5555, 1'b1);
    drive_op("illegal", 1'b1, 4'd12, 16'h5555, 1'b1);
    drive_op("idle_cla", 1'b0, 4'd3, 16'h5555, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic       v;
      logic [3:0] o;
      v = ($urandom_range(0, 9) != 0);
      o = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      drive_op("rand", v, o, 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ac_e_register.md
# ac_e_register

Accumulator (AC) and extension flip-flop (E) register stage of the basic computer datapath. It captures the 16-bit result and E output of the AND/ADD ALU, executes the register-reference operations on AC/E (clear, complement, circulate, increment), and presents AC back to the ALU's A input. It also drives the condition flags the control unit uses for skip decisions.

## Interface
Parameters:
- WIDTH, 16, data width of AC, ALU result and ALU operands.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- op_valid  input  1  qualifies op; one operation is executed per cycle while high.
- op  input  4  operation code (encoding below).
- alu_result  input  WIDTH  ALU Result.
- alu_e  input  1  ALU E (carry-out on ADD, 0 on AND).
- ac  output  WIDTH  accumulator register; feeds ALU A input.
- e  output  1  extension flip-flop.
- flag_zero  output  1  ac == 0.
- flag_neg  output  1  ac[WIDTH-1].
- flag_e_zero  output  1  e == 0.
- op_done  output  1  one-cycle pulse: a legal op completed on the previous edge.
- op_err  output  1  one-cycle pulse: an illegal op was presented on the previous edge.

## Operation
- Op encoding: 0 NOP, 1 LDAE ({e,ac} <= {alu_e,alu_result}), 2 LDA (ac <= alu_result, e held), 3 CLA (ac <= 0), 4 CLE (e <= 0), 5 CMA (ac <= ~ac), 6 CME (e <= ~e), 7 CIR ({ac,e} <= {e,ac}; e <= ac[0], ac <= {e,ac[WIDTH-1:1]}), 8 CIL ({e,ac} <= {ac,e}; e <= ac[WIDTH-1], ac <= {ac[WIDTH-2:0],e}), 9 INC (ac <= ac+1 mod 2^WIDTH, e held), 10–15 illegal.
- op_valid low: ac, e held; op_done, op_err low next cycle.
- NOP with op_valid high: no state change, op_done pulses.
- Illegal op: ac, e held; op_err pulses, op_done stays low.
- INC wrap: 0xFFFF -> 0x0000, e unchanged (no carry into E).
- CIR/CIL use pre-edge values of ac and e for both fields (true rotate through E, WIDTH+1 bits).
- Flags are combinational from registered ac/e only; never from alu_result or op.
- Back-to-back ops on consecutive cycles are legal; each sees the result of the previous one.

## Timing
- All state updates on rising clk when op_valid high; latency one edge: ac/e reflect op on the cycle after presentation.
- op_done/op_err registered, asserted during the cycle in which the new ac/e are visible, for exactly one cycle per accepted op.
- Reset (rst_n low, any time, including mid-stream): ac = 0, e = 0, op_done = 0, op_err = 0 immediately, without clock; hence flag_zero = 1, flag_neg = 0, flag_e_zero = 1. An op presented during reset is discarded. First op accepted on the first rising edge with rst_n high.
- alu_result/alu_e are sampled only on LDAE/LDA edges; the combinational loop ac -> ALU -> alu_result is broken by the register.

## Structure
- Shared package basic_computer_pkg: WIDTH constant, 4-bit op encoding constants (OP_NOP … OP_INC), illegal-op boundary.
- Single module; no sub-module needed. Next-state logic in one combinational case on op, registers in one async-reset process.

## Test plan
- Reset: drive rst_n low mid-cycle with ac = 0x1234 -> ac = 0x0000, e = 0, flag_zero = 1, op_done = 0 before next edge.
- LDAE with alu_result = 0xFFFF, alu_e = 1 -> ac = 0xFFFF, e = 1, flag_neg = 1, op_done pulse; then LDA with 0x00A5, alu_e = 0 -> ac = 0x00A5, e = 1.
- Rotate: ac = 0x8001, e = 0, CIR -> ac = 0x4000, e = 1; CIL -> ac = 0x8001, e = 0; 17 consecutive CIL restore original {e,ac}.
- INC wrap: ac = 0xFFFF, e = 0, INC -> ac = 0x0000, e = 0, flag_zero = 1; CMA -> 0xFFFF; CME -> e = 1, flag_e_zero = 0.
- Illegal/idle: op = 12 with op_valid high -> state held, op_err one cycle, op_done low; op = CLA with op_valid low -> no change, no pulses.
